// File: rtl/pixel_sink.sv
// Pixel write back end: range check, linear addressing, FIFO, memory port mux and screen clear.
// Define PIXEL_SINK_CLEAR_EN to compile in the clear engine; otherwise a clear request completes at once.
module pixel_sink #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WIDTH      = 160,
  parameter int unsigned HEIGHT     = 120
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          writeEn,
  input  logic [7:0]                    X,
  input  logic [6:0]                    Y,
  input  logic [5:0]                    colour,
  input  logic                          enable,
  input  logic [5:0]                    clear_colour,
  output logic                          complete,
  output logic                          busy,
  input  logic                          scan_req,
  input  logic [14:0]                   scan_addr,
  output logic [14:0]                   fb_addr,
  output logic [5:0]                    fb_data,
  output logic                          fb_wren,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  XLimit = 8'(WIDTH);
  localparam logic [7:0]  YLimit = 8'(HEIGHT);

  typedef struct packed {
    logic [14:0] addr;
    logic [5:0]  col;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StClear, StDone, StHold} state_e;

  entry_t         mem_q [FIFO_DEPTH];
  entry_t         head;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, count_d;
  logic           overflow_q;
  logic           in_range, full, push, pop;
  logic [14:0]    pix_addr;
  state_e         state_q, state_d;

  assign in_range = writeEn && (X < XLimit) && ({1'b0, Y} < YLimit);
  assign pix_addr = ({8'b0, Y} << 7) + ({8'b0, Y} << 5) + {7'b0, X};
  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign head     = mem_q[rd_ptr_q];
  // A clear owns the port ahead of the FIFO, so queued pixels land on top of the fill.
  assign pop      = (count_q != '0) && !scan_req && (state_q != StClear);
  assign push     = in_range && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{addr: pix_addr, col: colour};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= StIdle;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (in_range && full && !pop) overflow_q <= 1'b1;
      state_q <= state_d;
    end
  end

`ifdef PIXEL_SINK_CLEAR_EN
  localparam logic [14:0] LastAddr = 15'(WIDTH * HEIGHT - 1);

  logic [14:0] clr_cnt_q;
  logic [5:0]  clr_col_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt_q <= '0;
      clr_col_q <= '0;
    end else if (state_q == StIdle && enable) begin
      clr_cnt_q <= '0;
      clr_col_q <= clear_colour;
    end else if (state_q == StClear && !scan_req) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end
`else
  logic unused_clear_colour;
  assign unused_clear_colour = ^clear_colour;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
`ifdef PIXEL_SINK_CLEAR_EN
        if (enable) state_d = StClear;
`else
        if (enable) state_d = StDone;
`endif
      end
`ifdef PIXEL_SINK_CLEAR_EN
      StClear: if (!scan_req && clr_cnt_q == LastAddr) state_d = StDone;
`endif
      StDone:  state_d = StHold;
      StHold:  if (!enable) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fb_addr = '0;
    fb_data = '0;
    fb_wren = 1'b0;
    if (scan_req) begin
      fb_addr = scan_addr;
`ifdef PIXEL_SINK_CLEAR_EN
    end else if (state_q == StClear) begin
      fb_addr = clr_cnt_q;
      fb_data = clr_col_q;
      fb_wren = 1'b1;
`endif
    end else if (count_q != '0) begin
      fb_addr = head.addr;
      fb_data = head.col;
      fb_wren = 1'b1;
    end
  end

  assign complete   = (state_q == StDone);
  assign busy       = (state_q == StClear) || (state_q == StDone);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_pixel_sink.sv
// Self-checking bench for pixel_sink: queue-based reference model compared every cycle,
// directed test-plan scenarios with literal expectations, then randomized traffic.
module tb_pixel_sink;

  logic        clk = 1'b0;
  logic        reset, writeEn, enable, scan_req;
  logic [7:0]  X;
  logic [6:0]  Y;
  logic [5:0]  colour, clear_colour;
  logic [14:0] scan_addr;
  logic        complete, busy, fb_wren, overflow;
  logic [14:0] fb_addr;
  logic [5:0]  fb_data;
  logic [3:0]  fifo_count;

  pixel_sink dut (
    .clk(clk), .reset(reset), .writeEn(writeEn), .X(X), .Y(Y), .colour(colour),
    .enable(enable), .clear_colour(clear_colour), .complete(complete), .busy(busy),
    .scan_req(scan_req), .scan_addr(scan_addr), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_wren(fb_wren), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int unsigned total = 0, passed = 0;
  int unsigned n_complete = 0;
  bit started = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: queue of {addr*64 + colour}, clear phase 0 idle,1 clearing,2 done,3 hold.
  int q[$];
  bit m_ovf = 0;
  int phase = 0, clr_idx = 0, clr_col = 0;

  always @(posedge clk) begin : model
    bit pop, valid, full;
    if (reset) begin
      q.delete();
      m_ovf = 0;
      phase = 0;
      clr_idx = 0;
    end else begin
      pop   = !scan_req && phase != 1 && q.size() > 0;
      valid = writeEn && X < 160 && Y < 120;
      full  = q.size() == 8;
      if (pop) void'(q.pop_front());
      if (valid) begin
        if (!full || pop) q.push_back((int'(Y) * 160 + int'(X)) * 64 + int'(colour));
        else m_ovf = 1;
      end
      case (phase)
        0: if (enable) begin
`ifdef PIXEL_SINK_CLEAR_EN
          phase = 1; clr_idx = 0; clr_col = int'(clear_colour);
`else
          phase = 2;
`endif
        end
        1: if (!scan_req) begin
          if (clr_idx == 160 * 120 - 1) phase = 2;
          else clr_idx++;
        end
        2: phase = 3;
        default: if (!enable) phase = 0;
      endcase
    end
    started = 1;
  end

  always @(negedge clk) begin : compare
    int ea, ed;
    bit ew, dchk;
    if (started) begin
      ed = 0;
      if (scan_req) begin
        ea = int'(scan_addr); ew = 0; dchk = 0;
      end else if (phase == 1) begin
        ea = clr_idx; ed = clr_col; ew = 1; dchk = 1;
      end else if (q.size() > 0) begin
        ea = q[0] / 64; ed = q[0] % 64; ew = 1; dchk = 1;
      end else begin
        ea = 0; ew = 0; dchk = 1;
      end
      check("fb_addr", int'(fb_addr), ea);
      check("fb_wren", int'(fb_wren), int'(ew));
      if (dchk) check("fb_data", int'(fb_data), ed);
      check("fifo_count", int'(fifo_count), q.size());
      check("overflow", int'(overflow), int'(m_ovf));
      check("complete", int'(complete), int'(phase == 2));
      check("busy", int'(busy), int'(phase == 1 || phase == 2));
      if (complete) n_complete++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k, n;
    bit found;
    reset = 1; writeEn = 0; X = 0; Y = 0; colour = 0; enable = 0; clear_colour = 0;
    scan_req = 0; scan_addr = 0;
    cyc(); cyc();
    @(negedge clk);
    check("rst_wren", int'(fb_wren), 0);
    check("rst_addr", int'(fb_addr), 0);
    check("rst_data", int'(fb_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_overflow", int'(overflow), 0);
    cyc();
    reset = 0;

    // Single pixel
    cyc();
    writeEn = 1; X = 3; Y = 2; colour = 6'h3F;
    cyc();
    writeEn = 0;
    @(negedge clk);
    check("single_wren", int'(fb_wren), 1);
    check("single_addr", int'(fb_addr), 323);
    check("single_data", int'(fb_data), 63);
    cyc();
    @(negedge clk);
    check("single_wren_once", int'(fb_wren), 0);

    // Overflow under scan-out stall
    cyc();
    scan_req = 1; scan_addr = 15'h1234;
    for (int i = 0; i < 10; i++) begin
      writeEn = 1; X = 8'(10 + i); Y = 1; colour = 6'(i);
      cyc();
    end
    writeEn = 0;
    @(negedge clk);
    check("ovf_count", int'(fifo_count), 8);
    check("ovf_flag", int'(overflow), 1);
    cyc();
    scan_req = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("drain_addr", int'(fb_addr), 170 + i);
      check("drain_data", int'(fb_data), i);
      cyc();
    end
    @(negedge clk);
    check("drain_done_wren", int'(fb_wren), 0);
    check("ovf_sticky", int'(overflow), 1);
    reset = 1;
    cyc();
    reset = 0;
    @(negedge clk);
    check("ovf_cleared", int'(overflow), 0);

    // Range check
    cyc();
    writeEn = 1; X = 160; Y = 0;
    cyc();
    X = 0; Y = 120;
    cyc();
    writeEn = 0;
    @(negedge clk);
    check("range_wren", int'(fb_wren), 0);
    check("range_count", int'(fifo_count), 0);
    check("range_ovf", int'(overflow), 0);

    // Full FIFO with simultaneous pop
    cyc();
    scan_req = 1;
    for (int i = 0; i < 8; i++) begin
      writeEn = 1; X = 8'(20 + i); Y = 3; colour = 6'(i + 8);
      cyc();
    end
    scan_req = 0; X = 50; colour = 6'h2A;
    @(negedge clk);
    check("fullpop_head", int'(fb_addr), 500);
    cyc();
    writeEn = 0;
    @(negedge clk);
    check("fullpop_count", int'(fifo_count), 8);
    check("fullpop_ovf", int'(overflow), 0);
    for (int i = 0; i < 10; i++) cyc();

    // Clear request
    clear_colour = 6'h05; enable = 1;
    k = int'(n_complete);
`ifdef PIXEL_SINK_CLEAR_EN
    cyc();
    @(negedge clk);
    check("clr_first_addr", int'(fb_addr), 0);
    check("clr_first_data", int'(fb_data), 5);
    check("clr_first_busy", int'(busy), 1);
    for (int i = 0; i < 100; i++) cyc();
    writeEn = 1; X = 7; Y = 7; colour = 6'h2A;
    cyc();
    writeEn = 0;
    n = 101;
    found = 0;
    while (n < 20000 && !found) begin
      @(negedge clk);
      if (complete) found = 1;
      else begin n++; cyc(); end
    end
    check("clr_found_complete", int'(found), 1);
    check("clr_duration", n, 19200);
    check("clr_pixel_after", int'(fb_addr), 7 * 160 + 7);
    for (int i = 0; i < 20; i++) cyc();
    check("clr_single_pulse", int'(n_complete) - k, 1);
    enable = 0;
    cyc(); cyc();
    // Reset mid-clear at counter 500
    enable = 1;
    cyc();
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (fb_addr == 15'd500) found = 1;
      else cyc();
    end
    check("midclr_found_500", int'(found), 1);
    reset = 1; enable = 0;
    k = int'(n_complete);
    cyc();
    reset = 0;
    @(negedge clk);
    check("midclr_wren", int'(fb_wren), 0);
    check("midclr_busy", int'(busy), 0);
    check("midclr_count", int'(fifo_count), 0);
    for (int i = 0; i < 30; i++) cyc();
    check("midclr_no_complete", int'(n_complete) - k, 0);
`else
    @(negedge clk);
    check("clr_idle_complete", int'(complete), 0);
    cyc();
    @(negedge clk);
    check("clr_done_complete", int'(complete), 1);
    check("clr_done_busy", int'(busy), 1);
    check("clr_done_nowrite", int'(fb_wren), 0);
    cyc();
    @(negedge clk);
    check("clr_hold_busy", int'(busy), 0);
    for (int i = 0; i < 20; i++) cyc();
    check("clr_single_pulse", int'(n_complete) - k, 1);
    enable = 0;
    cyc(); cyc();
    enable = 1;
    cyc();
    @(negedge clk);
    check("clr_retrigger", int'(complete), 1);
    enable = 0;
    // Reset with pixels queued
    scan_req = 1;
    for (int i = 0; i < 4; i++) begin
      writeEn = 1; X = 8'(i); Y = 5; colour = 6'(i);
      cyc();
    end
    writeEn = 0; reset = 1;
    cyc();
    reset = 0; scan_req = 0;
    @(negedge clk);
    check("rstq_count", int'(fifo_count), 0);
    check("rstq_wren", int'(fb_wren), 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      writeEn   = ($urandom_range(0, 3) != 0);
      X         = 8'($urandom_range(0, 175));
      Y         = 7'($urandom_range(0, 127));
      colour    = 6'($urandom);
      scan_req  = ($urandom_range(0, 3) == 0);
      scan_addr = 15'($urandom);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      clear_colour = 6'($urandom);
      reset     = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 0; writeEn = 0; scan_req = 0; enable = 0;
    cyc(); cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pixel_sink.md
# pixel_sink

Back end of the pixel-write interface driven by the game controller (`X`, `Y`, `colour`, `writeEn`). It accepts one pixel per cycle, converts (X, Y) to a linear framebuffer address, and buffers writes in a small FIFO. It drains them into the 160x120, 6-bit-colour framebuffer memory port, yielding to VGA scan-out reads. It also provides a full-screen clear engine using the team's `enable`/`complete` module handshake.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: pixel FIFO entries; power of 2, minimum 2.
- `WIDTH`, 160: screen width in pixels.
- `HEIGHT`, 120: screen height in pixels.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `writeEn`  in  1  pixel write strobe; one pixel per cycle while high.
- `X`  in  8  pixel column.
- `Y`  in  7  pixel row.
- `colour`  in  6  pixel colour.
- `enable`  in  1  clear request; level, held by the requester until it sees `complete`.
- `clear_colour`  in  6  fill colour; sampled when a clear starts.
- `complete`  out  1  one-cycle pulse when a clear finishes.
- `busy`  out  1  high while a clear is in progress.
- `scan_req`  in  1  scan-out owns the memory port this cycle.
- `scan_addr`  in  15  scan-out read address.
- `fb_addr`  out  15  framebuffer address.
- `fb_data`  out  6  framebuffer write data.
- `fb_wren`  out  1  framebuffer write enable.
- `fifo_count`  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky flag: a valid pixel was dropped because the FIFO was full.

## Operation
- Enqueue: a pixel is pushed when `writeEn`=1, `X`<`WIDTH` and `Y`<`HEIGHT`. The stored entry is {addr = Y*160+X (15 bits, computed as (Y<<7)+(Y<<5)+X), colour}.
- Out-of-range pixels are discarded. They do not set `overflow`.
- Full FIFO: a push with no pop in the same cycle is dropped and sets `overflow`. `overflow` clears only on `reset`.
- Full FIFO with a simultaneous pop: the push is accepted and `fifo_count` is unchanged.
- Port mux, in priority order (combinational):
  - `scan_req`=1: `fb_addr`=`scan_addr`, `fb_wren`=0, no pop, clear counter holds.
  - State CLEAR: `fb_addr`=clear counter, `fb_data`=latched clear colour, `fb_wren`=1, counter increments.
  - FIFO non-empty: head entry driven onto `fb_addr`/`fb_data`, `fb_wren`=1, pop.
  - Otherwise: `fb_addr`=0, `fb_data`=0, `fb_wren`=0.
- Clear FSM:
  - IDLE: `enable`=1 → latch `clear_colour`, counter:=0, go to CLEAR.
  - CLEAR: after the write at address WIDTH*HEIGHT-1 (19199) → DONE.
  - DONE: `complete`=1 for this cycle only → HOLD.
  - HOLD: wait for `enable`=0 → IDLE. A clear never retriggers while `enable` stays high.
- Pushes continue during CLEAR. Queued pixels drain after the clear, so they land on top of the fill.
- `busy`=1 in CLEAR and DONE.
- Reset mid-operation: FIFO empties, FSM returns to IDLE, any clear in progress is abandoned with no `complete`, `overflow` clears.

## Timing
- Reset values: `fb_wren`=0, `fb_addr`=0, `fb_data`=0, `complete`=0, `busy`=0, `overflow`=0, `fifo_count`=0.
- Write latency: a pixel pushed in cycle N drives `fb_wren` in cycle N+1 at the earliest (FIFO empty, no `scan_req`, IDLE).
- Throughput: one pixel write per cycle sustained. The FIFO never fills unless `scan_req` or a clear stalls draining.
- Clear duration: 19200 write cycles plus one cycle per `scan_req` stall cycle.
- `complete` asserts in the cycle after the last clear write.
- `fifo_count` and `overflow` are registered and reflect pushes/pops from the previous edge.

## Configuration
- `PIXEL_SINK_CLEAR_EN` defined: clear engine as described above.
- Not defined: no clear logic or colour latch is compiled in.
  - `enable` → IDLE→DONE→HOLD, so `complete` pulses one cycle after `enable` rises, with no memory writes.
  - `busy` high only in that DONE cycle.
  - The controller never hangs.

## Test plan
- Single pixel: X=3, Y=2, colour=6'h3F, `writeEn` for 1 cycle → next cycle `fb_addr`=323, `fb_data`=6'h3F, `fb_wren`=1 for exactly one cycle.
- Overflow: hold `scan_req`=1, push 10 distinct pixels → `fifo_count`=8, `overflow`=1. Release → 8 consecutive writes of the first 8 pixels, in order.
- Range check: push X=160,Y=0 and X=0,Y=120 → no `fb_wren`, `fifo_count`=0, `overflow`=0.
- Clear: `clear_colour`=6'h05, `enable` held high → writes addr 0..19199 on consecutive cycles, then `complete` pulses once. No second clear until `enable` drops and rises again. A pixel pushed mid-clear is written after address 19199.
- Full plus simultaneous pop: fill the FIFO with `scan_req`=1, drop `scan_req` while pushing a 9th pixel → pixel accepted, `fifo_count` stays 8, `overflow` stays 0.
- Reset mid-clear at counter=500 → next cycle `fb_wren`=0, `busy`=0, `fifo_count`=0, and `complete` never pulses.
